seq_det_ctrl: RTL

- Sequencer that feeds a serial sequence detector (single-bit input w, registered single-bit output z, synchronous active-low reset).
- Accepts a parallel word over a valid/ready handshake and clears the detector.
- Shifts the word into the detector LSB first, one bit per cycle, and records which bit positions produced a detection.
- Sits between a word source (test driver or CPU register) and the detector instance; owns the detector's w input and reset.

---
 rtl/seq_det_ctrl_pkg.sv | 19 +
 rtl/seq_piso.sv | 30 +++
 rtl/seq_det_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/seq_det_ctrl_pkg.sv
// seq_det_ctrl shared types: FSM state encoding, default word width
// and an index-width helper.
package seq_det_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        SHIFT,
        DRAIN,
        DONE
    } state_e;

    localparam int WORD_W_DEF = 16;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_piso.sv
// Parallel-load, LSB-first shift register; cur_bit is the bit
// currently presented to the detector.
module seq_piso
    import seq_det_ctrl_pkg::*;
#(
    parameter int WIDTH = WORD_W_DEF
) (
    input  logic             clk_i,
    input  logic             res_i,
    input  logic             load_en,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] data,
    output logic             cur_bit
);

    logic [WIDTH-1:0] sr;

    always_ff @(posedge clk_i) begin
        if (res_i) begin
            sr <= '0;
        end else if (load_en) begin
            sr <= data;
        end else if (shift_en) begin
            sr <= sr >> 1;
        end
    end

    assign cur_bit = sr[0];

endmodule

// File: rtl/seq_det_ctrl.sv
// Word sequencer for a serial sequence detector: clears it, shifts a word
// in LSB first and maps detections. SEQ_DET_CTRL_CONT_EN: continuous mode.
module seq_det_ctrl
    import seq_det_ctrl_pkg::*;
#(
    parameter int WORD_W  = WORD_W_DEF,
    parameter int CNT_W   = $clog2(WORD_W + 1),
    parameter int CLR_CYC = 1
) (
    input  logic              clk_i,
    input  logic              res_i,
    input  logic [WORD_W-1:0] word_i,
    input  logic              word_valid_i,
    output logic              word_ready_o,
    input  logic              abort_i,
    output logic              det_w_o,
    output logic              det_res_no,
    input  logic              det_z_i,
    output logic [WORD_W-1:0] hit_map_o,
    output logic [CNT_W-1:0]  hit_cnt_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int IDX_W = idx_w(WORD_W);
    localparam int CLR_W = idx_w(CLR_CYC);
    localparam logic [IDX_W-1:0] K_LAST = IDX_W'(WORD_W - 1);
    localparam logic [CLR_W-1:0] C_LAST = CLR_W'(CLR_CYC - 1);

    state_e           state;
    logic [IDX_W-1:0] k;
    logic [CLR_W-1:0] clr_cnt;
    logic             abort_q;
    logic             load_en;
    logic             shift_en;
    logic             piso_bit;

    assign load_en    = word_valid_i & word_ready_o;
    assign shift_en   = (state == SHIFT) & ~abort_i;
    assign det_w_o    = (state == SHIFT) & piso_bit;
    assign det_res_no = ~(res_i | (state == CLR));

    seq_piso #(
        .WIDTH(WORD_W)
    ) u_piso (
        .clk_i   (clk_i),
        .res_i   (res_i),
        .load_en (load_en),
        .shift_en(shift_en),
        .data    (word_i),
        .cur_bit (piso_bit)
    );

    always_ff @(posedge clk_i) begin
        if (res_i) begin
            state        <= IDLE;
            k            <= '0;
            clr_cnt      <= '0;
            abort_q      <= 1'b0;
            word_ready_o <= 1'b1;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            hit_map_o    <= '0;
            hit_cnt_o    <= '0;
        end else begin
            done_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (load_en) begin
                        state        <= CLR;
                        clr_cnt      <= '0;
                        word_ready_o <= 1'b0;
                        busy_o       <= 1'b1;
                        hit_map_o    <= '0;
                        hit_cnt_o    <= '0;
                    end
                end
                CLR: begin
                    if (clr_cnt == C_LAST) begin
                        if (abort_q) begin
                            state        <= IDLE;
                            abort_q      <= 1'b0;
                            word_ready_o <= 1'b1;
                            busy_o       <= 1'b0;
                        end else begin
                            state <= SHIFT;
                            k     <= '0;
                        end
                    end else begin
                        clr_cnt <= clr_cnt + CLR_W'(1);
                    end
                end
                SHIFT, DRAIN: begin
                    if (abort_i) begin
                        state     <= CLR;
                        clr_cnt   <= '0;
                        abort_q   <= 1'b1;
                        hit_map_o <= '0;
                        hit_cnt_o <= '0;
                    end else if (state == SHIFT) begin
                        // z seen now answers the bit shifted last cycle
                        if (k != '0) begin
                            hit_map_o[k - IDX_W'(1)] <= det_z_i;
                            hit_cnt_o <= hit_cnt_o + CNT_W'(det_z_i);
                        end
                        if (k == K_LAST) begin
                            state <= DRAIN;
                        end else begin
                            k <= k + IDX_W'(1);
                        end
                    end else begin
                        hit_map_o[WORD_W-1] <= det_z_i;
                        hit_cnt_o <= hit_cnt_o + CNT_W'(det_z_i);
                        state     <= DONE;
                        done_o    <= 1'b1;
`ifdef SEQ_DET_CTRL_CONT_EN
                        word_ready_o <= 1'b1;
`endif
                    end
                end
                DONE: begin
`ifdef SEQ_DET_CTRL_CONT_EN
                    // detector is left running across the word boundary
                    if (word_valid_i) begin
                        state        <= SHIFT;
                        k            <= '0;
                        word_ready_o <= 1'b0;
                        hit_map_o    <= '0;
                        hit_cnt_o    <= '0;
                    end else begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
`else
                    state        <= IDLE;
                    word_ready_o <= 1'b1;
                    busy_o       <= 1'b0;
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
